// File: rtl/pm_loader.sv
// Boot loader: streams host bytes into PMD_SIZE-bit words and writes them to program memory.
// One PM write per PMD_SIZE/8+1 cycles at full host rate; host_ready drops during WRITE, DONE, ERR and IDLE.
module pm_loader #(
  parameter int PMA_SIZE = 16,
  parameter int PMD_SIZE = 48
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_start,
  input  logic [7:0]          host_dt,
  input  logic                host_valid,
  output logic                host_ready,
  output logic                ldr_pm_cslt,
  output logic                ldr_pm_wrb,
  output logic [PMA_SIZE-1:0] ldr_pm_add,
  output logic [PMD_SIZE-1:0] ldr_pm_dt,
  output logic                core_hold,
  output logic                load_done,
  output logic                load_err
);

  localparam int BPW = PMD_SIZE / 8;
  localparam int BIW = $clog2((BPW > 4) ? BPW : 4);
  localparam logic [BIW-1:0] HDR_LAST = BIW'(3);
  localparam logic [BIW-1:0] DAT_LAST = BIW'(BPW - 1);

  typedef enum logic [2:0] {IDLE, HDR, DATA, WRITE, DONE, ERR} state_t;

  state_t                state, state_nxt;
  logic [BIW-1:0]        byte_idx;
  logic [23:0]           hdr_q;
  logic [31:0]           hdr_nxt;
  logic [PMA_SIZE-1:0]   addr;
  logic [15:0]           remain;
  logic [PMD_SIZE-9:0]   asm_q;
  logic [PMD_SIZE-1:0]   asm_nxt;
  logic                  accept;

  // The last header/data byte is merged on the fly so the decision needs no extra cycle.
  assign hdr_nxt = {hdr_q, host_dt};
  assign asm_nxt = {asm_q, host_dt};
  assign accept  = host_valid && host_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERR: if (load_start) state_nxt = HDR;
      HDR:   if (accept && byte_idx == HDR_LAST)
               state_nxt = (hdr_nxt[15:0] == 16'd0) ? DONE : DATA;
      DATA:  if (accept && byte_idx == DAT_LAST) state_nxt = WRITE;
      WRITE: begin
        if (remain == 16'd1) state_nxt = DONE;
        else if (&addr)      state_nxt = ERR;
        else                 state_nxt = DATA;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    host_ready  = (state == HDR) || (state == DATA);
    ldr_pm_cslt = (state == WRITE);
    ldr_pm_wrb  = (state == WRITE);
    core_hold   = (state != DONE);
    load_done   = (state == DONE);
    load_err    = (state == ERR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_idx   <= '0;
      hdr_q      <= '0;
      addr       <= '0;
      remain     <= '0;
      asm_q      <= '0;
      ldr_pm_add <= '0;
      ldr_pm_dt  <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERR: if (load_start) byte_idx <= '0;
        HDR: if (accept) begin
          hdr_q <= hdr_nxt[23:0];
          if (byte_idx == HDR_LAST) begin
            byte_idx <= '0;
            addr     <= hdr_nxt[16 +: PMA_SIZE];
            remain   <= hdr_nxt[15:0];
          end else begin
            byte_idx <= byte_idx + 1'b1;
          end
        end
        DATA: if (accept) begin
          // PM port registers load here so they are stable for the whole WRITE cycle and hold after.
          if (byte_idx == DAT_LAST) begin
            byte_idx   <= '0;
            ldr_pm_add <= addr;
            ldr_pm_dt  <= asm_nxt;
          end else begin
            byte_idx <= byte_idx + 1'b1;
            asm_q    <= asm_nxt[PMD_SIZE-9:0];
          end
        end
        WRITE: begin
          remain <= remain - 16'd1;
          if (remain != 16'd1 && !(&addr)) addr <= addr + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pm_loader.sv
// Directed bench for pm_loader: header parsing, word writes, overflow, stalls and async reset.
module tb_pm_loader;
  logic        clk = 1'b0;
  logic        reset;
  logic        load_start;
  logic [7:0]  host_dt;
  logic        host_valid;
  logic        host_ready;
  logic        ldr_pm_cslt;
  logic        ldr_pm_wrb;
  logic [15:0] ldr_pm_add;
  logic [47:0] ldr_pm_dt;
  logic        core_hold;
  logic        load_done;
  logic        load_err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [15:0] wr_add[$];
  logic [47:0] wr_dt[$];
  int          wr_cyc[$];
  logic        wr_rdy[$];
  logic [7:0]  tx_q[$];

  pm_loader #(.PMA_SIZE(16), .PMD_SIZE(48)) dut (
    .clk(clk), .reset(reset), .load_start(load_start),
    .host_dt(host_dt), .host_valid(host_valid), .host_ready(host_ready),
    .ldr_pm_cslt(ldr_pm_cslt), .ldr_pm_wrb(ldr_pm_wrb),
    .ldr_pm_add(ldr_pm_add), .ldr_pm_dt(ldr_pm_dt),
    .core_hold(core_hold), .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ldr_pm_wrb || ldr_pm_cslt) begin
      wr_add.push_back(ldr_pm_add);
      wr_dt.push_back(ldr_pm_dt);
      wr_cyc.push_back(cyc);
      wr_rdy.push_back(host_ready);
    end
  end

  task automatic clear_log();
    wr_add.delete(); wr_dt.delete(); wr_cyc.delete(); wr_rdy.delete();
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int bound, output bit ok);
    host_dt = b; host_valid = 1'b1; ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk);
      if (host_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  task automatic send_q(input bit gap, output int miss);
    bit ok;
    miss = 0;
    foreach (tx_q[i]) begin
      send_byte(tx_q[i], 16, ok);
      if (!ok) miss++;
      if (gap) begin
        host_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    host_valid = 1'b0;
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (load_done) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; load_start = 1'b0; host_dt = 8'h00; host_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (host_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready got %b want 0", host_ready); end
    n_cmp++; if ({ldr_pm_cslt, ldr_pm_wrb} !== 2'b00) begin n_bad++; $display("FAIL reset_strobes got %b want 00", {ldr_pm_cslt, ldr_pm_wrb}); end
    n_cmp++; if (ldr_pm_add !== 16'h0 || ldr_pm_dt !== 48'h0) begin n_bad++; $display("FAIL reset_pm got %h/%h want 0/0", ldr_pm_add, ldr_pm_dt); end
    n_cmp++; if ({core_hold, load_done, load_err} !== 3'b100) begin n_bad++; $display("FAIL reset_flags got %b want 100", {core_hold, load_done, load_err}); end
    reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (host_ready !== 1'b0) begin n_bad++; $display("FAIL idle_ready got %b want 0", host_ready); end
  endtask

  task automatic test_basic();
    int miss; bit seen;
    clear_log();
    pulse_start();
    n_cmp++; if (host_ready !== 1'b1) begin n_bad++; $display("FAIL basic_ready got %b want 1", host_ready); end
    tx_q = '{8'h00, 8'h10, 8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
             8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};
    send_q(1'b0, miss);
    n_cmp++; if (miss !== 0) begin n_bad++; $display("FAIL basic_accept got %0d missed want 0", miss); end
    wait_done(seen);
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL basic_done_timeout got %b want 1", seen); end
    n_cmp++; if (wr_add.size() !== 2) begin n_bad++; $display("FAIL basic_wr_count got %0d want 2", wr_add.size()); end
    if (wr_add.size() >= 2) begin
      n_cmp++; if (wr_add[0] !== 16'h0010 || wr_dt[0] !== 48'h010203040506) begin n_bad++; $display("FAIL basic_wr0 got %h/%h want 0010/010203040506", wr_add[0], wr_dt[0]); end
      n_cmp++; if (wr_add[1] !== 16'h0011 || wr_dt[1] !== 48'h0708090A0B0C) begin n_bad++; $display("FAIL basic_wr1 got %h/%h want 0011/0708090a0b0c", wr_add[1], wr_dt[1]); end
      n_cmp++; if (wr_cyc[1] - wr_cyc[0] !== 7) begin n_bad++; $display("FAIL basic_throughput got %0d want 7", wr_cyc[1] - wr_cyc[0]); end
      n_cmp++; if (wr_rdy[0] !== 1'b0) begin n_bad++; $display("FAIL basic_ready_in_write got %b want 0", wr_rdy[0]); end
    end
    n_cmp++; if ({load_done, core_hold, host_ready, load_err} !== 4'b1000) begin n_bad++; $display("FAIL basic_final got %b want 1000", {load_done, core_hold, host_ready, load_err}); end
  endtask

  task automatic test_zero();
    int miss;
    clear_log();
    pulse_start();
    tx_q = '{8'h12, 8'h34, 8'h00, 8'h00};
    send_q(1'b0, miss);
    n_cmp++; if (miss !== 0) begin n_bad++; $display("FAIL zero_accept got %0d missed want 0", miss); end
    n_cmp++; if ({load_done, core_hold} !== 2'b10) begin n_bad++; $display("FAIL zero_done_timing got %b want 10", {load_done, core_hold}); end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (wr_add.size() !== 0) begin n_bad++; $display("FAIL zero_no_write got %0d want 0", wr_add.size()); end
  endtask

  task automatic test_reload();
    int miss; bit seen;
    clear_log();
    pulse_start();
    n_cmp++; if ({core_hold, load_done} !== 2'b10) begin n_bad++; $display("FAIL reload_hold got %b want 10", {core_hold, load_done}); end
    tx_q = '{8'h00, 8'h20, 8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
    send_q(1'b0, miss);
    n_cmp++; if (miss !== 0) begin n_bad++; $display("FAIL reload_accept got %0d missed want 0", miss); end
    wait_done(seen);
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL reload_done_timeout got %b want 1", seen); end
    n_cmp++; if (wr_add.size() !== 1) begin n_bad++; $display("FAIL reload_wr_count got %0d want 1", wr_add.size()); end
    if (wr_add.size() >= 1) begin
      n_cmp++; if (wr_add[0] !== 16'h0020 || wr_dt[0] !== 48'hAABBCCDDEEFF) begin n_bad++; $display("FAIL reload_wr got %h/%h want 0020/aabbccddeeff", wr_add[0], wr_dt[0]); end
    end
    n_cmp++; if (core_hold !== 1'b0) begin n_bad++; $display("FAIL reload_release got %b want 0", core_hold); end
  endtask

  task automatic test_overflow();
    int miss; bit ok;
    clear_log();
    pulse_start();
    tx_q = '{8'hFF, 8'hFF, 8'h00, 8'h02, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
    send_q(1'b0, miss);
    n_cmp++; if (miss !== 0) begin n_bad++; $display("FAIL ovf_accept got %0d missed want 0", miss); end
    send_byte(8'h17, 10, ok);
    host_valid = 1'b0;
    n_cmp++; if (ok !== 1'b0) begin n_bad++; $display("FAIL ovf_extra_byte_taken got %b want 0", ok); end
    n_cmp++; if ({load_err, core_hold, host_ready, load_done} !== 4'b1100) begin n_bad++; $display("FAIL ovf_flags got %b want 1100", {load_err, core_hold, host_ready, load_done}); end
    n_cmp++; if (wr_add.size() !== 1) begin n_bad++; $display("FAIL ovf_wr_count got %0d want 1", wr_add.size()); end
    if (wr_add.size() >= 1) begin
      n_cmp++; if (wr_add[0] !== 16'hFFFF || wr_dt[0] !== 48'h111213141516) begin n_bad++; $display("FAIL ovf_wr got %h/%h want ffff/111213141516", wr_add[0], wr_dt[0]); end
    end
  endtask

  task automatic test_gap();
    int miss; bit seen;
    clear_log();
    pulse_start();
    n_cmp++; if (load_err !== 1'b0) begin n_bad++; $display("FAIL gap_err_cleared got %b want 0", load_err); end
    tx_q = '{8'h00, 8'h05, 8'h00, 8'h01, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
    send_q(1'b1, miss);
    n_cmp++; if (miss !== 0) begin n_bad++; $display("FAIL gap_accept got %0d missed want 0", miss); end
    wait_done(seen);
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL gap_done_timeout got %b want 1", seen); end
    n_cmp++; if (wr_add.size() !== 1) begin n_bad++; $display("FAIL gap_wr_count got %0d want 1", wr_add.size()); end
    if (wr_add.size() >= 1) begin
      n_cmp++; if (wr_add[0] !== 16'h0005 || wr_dt[0] !== 48'hA1A2A3A4A5A6) begin n_bad++; $display("FAIL gap_wr got %h/%h want 0005/a1a2a3a4a5a6", wr_add[0], wr_dt[0]); end
      n_cmp++; if (wr_rdy[0] !== 1'b0) begin n_bad++; $display("FAIL gap_ready_in_write got %b want 0", wr_rdy[0]); end
    end
  endtask

  task automatic test_reset_mid();
    int miss; bit seen;
    clear_log();
    pulse_start();
    tx_q = '{8'h00, 8'h30, 8'h00, 8'h01, 8'hB1, 8'hB2, 8'hB3};
    send_q(1'b0, miss);
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (host_ready !== 1'b0) begin n_bad++; $display("FAIL mid_ready got %b want 0", host_ready); end
    n_cmp++; if (ldr_pm_add !== 16'h0 || ldr_pm_dt !== 48'h0) begin n_bad++; $display("FAIL mid_pm got %h/%h want 0/0", ldr_pm_add, ldr_pm_dt); end
    n_cmp++; if ({core_hold, load_done, load_err} !== 3'b100) begin n_bad++; $display("FAIL mid_flags got %b want 100", {core_hold, load_done, load_err}); end
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (wr_add.size() !== 0) begin n_bad++; $display("FAIL mid_no_write got %0d want 0", wr_add.size()); end
    pulse_start();
    tx_q = '{8'h00, 8'h40, 8'h00, 8'h01, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6};
    send_q(1'b0, miss);
    n_cmp++; if (miss !== 0) begin n_bad++; $display("FAIL mid_reload_accept got %0d missed want 0", miss); end
    wait_done(seen);
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL mid_done_timeout got %b want 1", seen); end
    n_cmp++; if (wr_add.size() !== 1) begin n_bad++; $display("FAIL mid_wr_count got %0d want 1", wr_add.size()); end
    if (wr_add.size() >= 1) begin
      n_cmp++; if (wr_add[0] !== 16'h0040 || wr_dt[0] !== 48'hC1C2C3C4C5C6) begin n_bad++; $display("FAIL mid_wr got %h/%h want 0040/c1c2c3c4c5c6", wr_add[0], wr_dt[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_reload();
    test_overflow();
    test_gap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
